// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: autonomous script runner for the SpiMasterPeripheral MMIO port.
// It fetches 16-bit entries from a sequence ROM and turns them into register writes,
// ready polls, chip-select / D/C control and programmable delays.
module spi_cmd_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int WR_HOLD      = 4,
    parameter int SETTLE       = 8,
    parameter int DELAY_UNIT   = 25000,
    parameter int POLL_TIMEOUT = 65535
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] seq_addr,
    input  logic [15:0]       seq_data,
    output logic              periph_rst,
    output logic [7:0]        mem_addr,
    output logic [3:0]        mem_wr_en,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data,
    output logic              spi_cs_n,
    output logic              oled_dc
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_WR, S_RST_WAIT, S_FETCH, S_DECODE,
        S_TX_WR, S_TX_SETTLE, S_POLL, S_DELAY, S_FINISH
    } state_t;

    localparam logic [31:0] HOLD_LAST   = 32'(WR_HOLD - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic [31:0] POLL_LAST   = 32'(POLL_TIMEOUT - 1);

    // One shared cycle counter; 32 bits covers 255 * DELAY_UNIT and POLL_TIMEOUT.
    state_t            state, state_d;
    logic [31:0]       cnt, cnt_d;
    logic [31:0]       delay_last, delay_last_d;
    logic [ADDR_W-1:0] seq_addr_d;
    logic [7:0]        tx_byte, tx_byte_d;
    logic              err_d, periph_rst_d, spi_cs_n_d, oled_dc_d;
    logic              ready, advance;
    logic              unused_bits;

    assign ready       = mem_rd_data[0];
    assign unused_bits = ^{mem_rd_data[31:1], seq_data[13:8]};

    // State and datapath registers; everything returns to its idle value on rst.
    // NOTE: registers take only non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            delay_last <= '0;
            seq_addr   <= '0;
            tx_byte    <= '0;
            err        <= 1'b0;
            periph_rst <= 1'b1;
            spi_cs_n   <= 1'b1;
            oled_dc    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            delay_last <= delay_last_d;
            seq_addr   <= seq_addr_d;
            tx_byte    <= tx_byte_d;
            err        <= err_d;
            periph_rst <= periph_rst_d;
            spi_cs_n   <= spi_cs_n_d;
            oled_dc    <= oled_dc_d;
        end
    end

    // Next-state and next-register logic for the script walker.
    // NOTE: every signal written here is given a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        delay_last_d = delay_last;
        seq_addr_d   = seq_addr;
        tx_byte_d    = tx_byte;
        err_d        = err;
        periph_rst_d = periph_rst;
        spi_cs_n_d   = spi_cs_n;
        oled_dc_d    = oled_dc;
        advance      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_RST_WR;
                    err_d        = 1'b0;
                    seq_addr_d   = '0;
                    periph_rst_d = 1'b0;
                    cnt_d        = '0;
                end
            end
            S_RST_WR: begin
                if (cnt == HOLD_LAST) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            S_RST_WAIT: begin
                if (ready) begin
                    state_d = S_FETCH;
                end else if (cnt == POLL_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                cnt_d = '0;
                case (seq_data[15:14])
                    2'b00, 2'b01: begin
                        oled_dc_d  = seq_data[14];
                        spi_cs_n_d = 1'b0;
                        tx_byte_d  = seq_data[7:0];
                        state_d    = S_TX_WR;
                    end
                    2'b10: begin
                        if (seq_data[7:0] == 8'd0) begin
                            advance = 1'b1;
                        end else begin
                            delay_last_d = 32'(seq_data[7:0]) * 32'(DELAY_UNIT) - 32'd1;
                            state_d      = S_DELAY;
                        end
                    end
                    default: state_d = S_FINISH;
                endcase
            end
            S_TX_WR: begin
                if (cnt == HOLD_LAST) begin
                    state_d = S_TX_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            S_TX_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_d = S_POLL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            S_POLL: begin
                if (ready) begin
                    advance = 1'b1;
                end else if (cnt == POLL_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            S_DELAY: begin
                if (cnt == delay_last) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Step to the next entry; running off the end of the ROM is an abort, not a wrap.
        if (advance) begin
            if (&seq_addr) begin
                err_d   = 1'b1;
                state_d = S_FINISH;
            end else begin
                seq_addr_d = seq_addr + 1'b1;
                state_d    = S_FETCH;
            end
        end

        // Chip-select is released on the way into FINISH, whatever the cause.
        if (state_d == S_FINISH) begin
            spi_cs_n_d = 1'b1;
        end
    end

    // Peripheral bus drive decoded from state; writes exist only in RST_WR and TX_WR.
    always_comb begin
        mem_addr    = 8'd3;
        mem_wr_en   = 4'b0000;
        mem_wr_data = 32'd0;
        case (state)
            S_RST_WR: begin
                mem_addr    = 8'd0;
                mem_wr_en   = 4'b0001;
                mem_wr_data = 32'h0000_0002;
            end
            S_TX_WR: begin
                mem_addr    = 8'd1;
                mem_wr_en   = 4'b0001;
                mem_wr_data = {24'h0, tx_byte};
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_FINISH);
    assign done = (state == S_FINISH);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: directed script table, hand-written reset and
// start-while-busy sequences, then random scripts checked against a script-level model.
module tb_spi_cmd_sequencer;

    localparam int ADDR_W       = 2;
    localparam int WR_HOLD      = 4;
    localparam int SETTLE       = 8;
    localparam int DELAY_UNIT   = 10;
    localparam int POLL_TIMEOUT = 50;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, err;
    logic [ADDR_W-1:0] seq_addr;
    logic [15:0]       seq_data;
    logic              periph_rst;
    logic [7:0]        mem_addr;
    logic [3:0]        mem_wr_en;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;
    logic              spi_cs_n, oled_dc;

    spi_cmd_sequencer #(
        .ADDR_W(ADDR_W), .WR_HOLD(WR_HOLD), .SETTLE(SETTLE),
        .DELAY_UNIT(DELAY_UNIT), .POLL_TIMEOUT(POLL_TIMEOUT)
    ) u_dut (
        .clk_in(clk_in), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .seq_addr(seq_addr), .seq_data(seq_data), .periph_rst(periph_rst),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .spi_cs_n(spi_cs_n), .oled_dc(oled_dc)
    );

    always #5 clk_in = ~clk_in;

    // ROM and peripheral models: ready stays 1 unless 'stall' makes it drop for good
    // once the first TX write has been seen.
    logic [15:0] rom [4];
    logic        stall;
    logic        tx_seen;
    assign seq_data    = rom[seq_addr];
    assign mem_rd_data = {31'd0, !(stall && tx_seen)};

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  en;
        logic [31:0] len;
        logic        dc;
        logic        cs;
    } wr_t;

    typedef struct packed {
        logic [31:0]      err;
        logic [31:0]      ntx;
        logic [31:0]      busy;
        logic [31:0]      addr;
        logic [3:0][7:0]  b;
        logic [3:0]       dc;
    } exp_t;

    typedef struct packed {
        logic [3:0][15:0] rom;
        logic             stall;
        logic [31:0]      exp_err;
        logic [31:0]      exp_ntx;
        logic [31:0]      exp_busy;
        logic [31:0]      exp_addr;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Bus monitor state (sampled on the falling edge).
    wr_t wq[$];
    wr_t cur;
    logic in_wr = 1'b0;
    logic cs_prev = 1'b1;
    int cyc = 0, busy_cnt = 0, done_cnt = 0, cs_rise = 0, done_cyc = 0, wr_end_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        cyc++;
        busy_cnt += int'(busy);
        done_cnt += int'(done);
        if (done) done_cyc = cyc;
        if (spi_cs_n && !cs_prev && busy) cs_rise++;
        cs_prev = spi_cs_n;
        if (mem_wr_en != 4'd0) begin
            if (!in_wr) begin
                cur.addr = mem_addr;
                cur.data = mem_wr_data;
                cur.en   = mem_wr_en;
                cur.len  = 32'd1;
                cur.dc   = oled_dc;
                cur.cs   = spi_cs_n;
                in_wr    = 1'b1;
            end else begin
                cur.len = cur.len + 32'd1;
            end
            if (mem_addr == 8'd1) tx_seen = 1'b1;
        end else if (in_wr) begin
            wq.push_back(cur);
            in_wr      = 1'b0;
            wr_end_cyc = cyc;
        end
    end

    // Script-level reference: walks the entries and totals the cycles each kind costs
    // (ready answers immediately unless stalled after the first TX write).
    function automatic exp_t model(input logic [3:0][15:0] r, input logic st);
        exp_t e;
        logic [1:0] t;
        e = '0;
        e.busy = 32'(WR_HOLD + 1);
        for (int i = 0; i < 4; i++) begin
            t = r[i][15:14];
            e.addr = 32'(i);
            if (t == 2'b11) begin
                e.busy = e.busy + 32'd2;
                return e;
            end else if (t == 2'b10) begin
                e.busy = e.busy + 32'd2 + 32'(r[i][7:0]) * 32'(DELAY_UNIT);
            end else begin
                e.b[e.ntx[1:0]]  = r[i][7:0];
                e.dc[e.ntx[1:0]] = t[0];
                e.ntx = e.ntx + 32'd1;
                if (st) begin
                    e.busy = e.busy + 32'(2 + WR_HOLD + SETTLE + POLL_TIMEOUT);
                    e.err  = 32'd1;
                    return e;
                end
                e.busy = e.busy + 32'(2 + WR_HOLD + SETTLE + 1);
            end
        end
        e.err = 32'd1;
        return e;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_seq_addr"}, 32'(seq_addr), 32'd0);
        check({tag, "_periph_rst"}, 32'(periph_rst), 32'd1);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd3);
        check({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'd0);
        check({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
        check({tag, "_spi_cs_n"}, 32'(spi_cs_n), 32'd1);
        check({tag, "_oled_dc"}, 32'(oled_dc), 32'd0);
    endtask

    // Runs one script to done; checks bus writes against the model, returns observed totals.
    task automatic run_script(input logic [3:0][15:0] r, input logic st, input int extra_at,
                              output logic [31:0] o_err, output logic [31:0] o_ntx,
                              output logic [31:0] o_busy, output logic [31:0] o_addr);
        exp_t m;
        int b0, d0, c0, nw;
        logic seen;
        m = model(r, st);
        for (int i = 0; i < 4; i++) rom[i] = r[i];
        stall   = st;
        tx_seen = 1'b0;
        wq.delete();
        b0 = busy_cnt; d0 = done_cnt; c0 = cs_rise;
        seen = 1'b0;
        @(posedge clk_in); #1 start = 1'b1;
        @(posedge clk_in); #1 start = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk_in); #1;
            if (k == extra_at) begin
                start = 1'b1;
                @(posedge clk_in); #1 start = 1'b0;
                check("start_busy_seq_addr", 32'(seq_addr), 32'd1);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_within_budget", 32'(seen), 32'd1);
        @(negedge clk_in);
        @(negedge clk_in);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cs_n", 32'(spi_cs_n), 32'd1);
        check("idle_periph_rst", 32'(periph_rst), 32'd0);
        check("cs_stays_low", 32'(cs_rise - c0), 32'd0);
        nw = wq.size();
        check("write_count", 32'(nw), m.ntx + 32'd1);
        if (nw > 0) begin
            check("ctrl_addr", 32'(wq[0].addr), 32'd0);
            check("ctrl_data", wq[0].data, 32'h2);
            check("ctrl_en", 32'(wq[0].en), 32'd1);
            check("ctrl_hold", wq[0].len, 32'(WR_HOLD));
            check("ctrl_cs_n", 32'(wq[0].cs), 32'd1);
        end
        for (int i = 1; i < nw && i <= int'(m.ntx); i++) begin
            check("tx_addr", 32'(wq[i].addr), 32'd1);
            check("tx_data", wq[i].data, {24'h0, m.b[i-1]});
            check("tx_en", 32'(wq[i].en), 32'd1);
            check("tx_hold", wq[i].len, 32'(WR_HOLD));
            check("tx_dc", 32'(wq[i].dc), 32'(m.dc[i-1]));
            check("tx_cs_n", 32'(wq[i].cs), 32'd0);
        end
        if (st && m.ntx != 0) begin
            check("timeout_cycles", 32'(done_cyc - wr_end_cyc), 32'(SETTLE + POLL_TIMEOUT));
        end
        o_err  = 32'(err);
        o_ntx  = 32'(nw - 1);
        o_busy = 32'(busy_cnt - b0);
        o_addr = 32'(seq_addr);
    endtask

    function automatic vec_t mk(input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3, input logic st,
                                input int x_err, input int x_ntx, input int x_busy, input int x_addr);
        vec_t v;
        v.rom      = {e3, e2, e1, e0};
        v.stall    = st;
        v.exp_err  = 32'(x_err);
        v.exp_ntx  = 32'(x_ntx);
        v.exp_busy = 32'(x_busy);
        v.exp_addr = 32'(x_addr);
        return v;
    endfunction

    initial begin
        vec_t tbl[6];
        logic [31:0] g_err, g_ntx, g_busy, g_addr;
        exp_t m;
        logic [3:0][15:0] rr;
        logic st;
        int sel;

        // Directed scripts with hand-derived totals: err, TX writes, busy cycles, final seq_addr.
        tbl[0] = mk(16'h0095, 16'h403A, 16'hC000, 16'h0000, 1'b0, 0, 2, 37, 2);
        tbl[1] = mk(16'h8003, 16'hC000, 16'h0000, 16'h0000, 1'b0, 0, 0, 39, 1);
        tbl[2] = mk(16'h00AE, 16'hC000, 16'h0000, 16'h0000, 1'b1, 1, 1, 69, 0);
        tbl[3] = mk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0, 1, 4, 65, 3);
        tbl[4] = mk(16'h8000, 16'h41FF, 16'hC000, 16'h0000, 1'b0, 0, 1, 24, 2);
        tbl[5] = mk(16'hC000, 16'h0095, 16'h0000, 16'h0000, 1'b0, 0, 0, 7, 0);

        rst = 1'b1; start = 1'b1; stall = 1'b0; tx_seen = 1'b0;
        for (int i = 0; i < 4; i++) rom[i] = 16'hC000;
        #23;
        check_reset_values("reset");
        @(posedge clk_in); #1 start = 1'b0;
        @(posedge clk_in); #1 rst = 1'b0;
        @(posedge clk_in); #1;
        check("idle_no_start_periph_rst", 32'(periph_rst), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_script(tbl[i].rom, tbl[i].stall, -1, g_err, g_ntx, g_busy, g_addr);
            check($sformatf("tbl%0d_err", i), g_err, tbl[i].exp_err);
            check($sformatf("tbl%0d_ntx", i), g_ntx, tbl[i].exp_ntx);
            check($sformatf("tbl%0d_busy", i), g_busy, tbl[i].exp_busy);
            check($sformatf("tbl%0d_seq_addr", i), g_addr, tbl[i].exp_addr);
        end

        // rst asserted mid-DELAY: outputs fall back at once, then a fresh run completes.
        rom[0] = 16'h80FF; rom[1] = 16'hC000; rom[2] = 16'h0000; rom[3] = 16'h0000;
        stall = 1'b0;
        @(posedge clk_in); #1 start = 1'b1;
        @(posedge clk_in); #1 start = 1'b0;
        repeat (20) @(posedge clk_in);
        #2;
        check("in_delay_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk_in); #1 rst = 1'b0;
        run_script(tbl[0].rom, 1'b0, -1, g_err, g_ntx, g_busy, g_addr);
        check("after_rst_err", g_err, 32'd0);
        check("after_rst_ntx", g_ntx, 32'd2);
        check("after_rst_busy", g_busy, 32'd37);

        // start pulsed while busy (entry 1 in flight) must change nothing.
        run_script(tbl[0].rom, 1'b0, 22, g_err, g_ntx, g_busy, g_addr);
        check("busy_start_err", g_err, 32'd0);
        check("busy_start_ntx", g_ntx, 32'd2);
        check("busy_start_busy", g_busy, 32'd37);

        // Random scripts against the model.
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 4; i++) begin
                sel = int'($urandom_range(0, 9));
                rr[i] = {2'b00, 6'($urandom), 8'($urandom)};
                if (sel >= 4 && sel <= 6) rr[i][15:14] = 2'b01;
                else if (sel == 7 || sel == 8) rr[i] = {2'b10, 6'($urandom), 8'($urandom_range(0, 3))};
                else if (sel == 9) rr[i][15:14] = 2'b11;
            end
            st = ($urandom_range(0, 3) == 0);
            m  = model(rr, st);
            run_script(rr, st, -1, g_err, g_ntx, g_busy, g_addr);
            check($sformatf("rnd%0d_err", n), g_err, m.err);
            check($sformatf("rnd%0d_ntx", n), g_ntx, m.ntx);
            check($sformatf("rnd%0d_busy", n), g_busy, m.busy);
            check($sformatf("rnd%0d_seq_addr", n), g_addr, m.addr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
Autonomous master for the MMIO port of SpiMasterPeripheral. It fetches 16-bit entries from an external sequence ROM, such as an OLED init script, and turns them into peripheral register writes and status polls. It drives chip-select and the display D/C line, and inserts programmable delays. The block sits between the boot logic and the SPI peripheral, so a display or SD card can be initialised without the CPU.

Parameters:
ADDR_W, 8, sequence ROM address width; a script is at most 2^ADDR_W entries.
WR_HOLD, 4, cycles that mem_wr_en is held asserted for each register write (≥1).
SETTLE, 8, cycles after a TX write is released before status polling begins (≥1).
DELAY_UNIT, 25000, clk_in cycles per delay tick (1 ms at 25 MHz).
POLL_TIMEOUT, 65535, maximum POLL cycles before aborting with an error.

Ports:
clk_in  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; starts the script at ROM entry 0; ignored while busy
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at script end (normal or abort)
err  out  1  sticky abort flag; cleared by the next accepted start
seq_addr  out  ADDR_W  ROM address; ROM data valid one cycle later
seq_data  in  16  ROM entry
periph_rst  out  1  reset to the SPI peripheral
mem_addr  out  8  peripheral word address (0=CTRL, 1=TX, 3=STATUS)
mem_wr_en  out  4  byte write enables
mem_wr_data  out  32  write data
mem_rd_data  in  32  peripheral read data; bit0 = ready
spi_cs_n  out  1  device chip-select, active-low
oled_dc  out  1  D/C: 0 = command, 1 = data

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, seq_addr=0, periph_rst=1, mem_addr=3, mem_wr_en=0, mem_wr_data=0, spi_cs_n=1, oled_dc=0.
  - State is IDLE.
- periph_rst deasserts on the first accepted start and stays 0 until rst.
- Entry format, seq_data[15:14]:
  - 00: CMD byte [7:0]
  - 01: DATA byte [7:0]
  - 10: DELAY of N=[7:0] ticks (N=0 means no wait)
  - 11: END
  - Bits [13:8] are ignored.
- States:
  - IDLE: on start, set busy=1, err=0, seq_addr=0, go to RST_WR.
  - RST_WR: mem_addr=0, mem_wr_data=0x00000002, mem_wr_en=0001 for WR_HOLD cycles, spi_cs_n=1. Then go to RST_WAIT.
  - RST_WAIT: mem_wr_en=0; poll ready as in POLL; go to FETCH.
  - FETCH: present seq_addr; wait one cycle for ROM data; go to DECODE.
  - DECODE:
    - CMD/DATA: set oled_dc=0 or 1 in this cycle, spi_cs_n=0, go to TX_WR.
    - DELAY: go to DELAY.
    - END: go to FINISH.
  - TX_WR: mem_addr=1, mem_wr_data={24'h0, byte}, mem_wr_en=0001 for WR_HOLD cycles. Then go to TX_SETTLE.
  - TX_SETTLE: mem_wr_en=0, mem_addr=3, count SETTLE cycles, then go to POLL.
  - POLL: mem_addr=3.
    - When mem_rd_data[0]=1: increment seq_addr, go to FETCH.
    - After POLL_TIMEOUT cycles without ready: set err=1, go to FINISH.
  - DELAY: count N×DELAY_UNIT cycles; spi_cs_n and oled_dc hold their values. Then increment seq_addr, go to FETCH.
  - FINISH: spi_cs_n=1, mem_wr_en=0, pulse done for 1 cycle, busy=0, go to IDLE.
- oled_dc is stable from DECODE through POLL; it changes only in DECODE.
- Wrap-around: incrementing seq_addr from 2^ADDR_W−1 without having decoded END sets err=1 and goes to FINISH. There is no wrap back to entry 0.
- The delay counter must hold 255×DELAY_UNIT without overflow.
- start while busy: ignored. No restart and no queuing.
- start coincident with rst: rst wins.
- rst mid-operation: all outputs return to reset values immediately (asynchronous). periph_rst returns to 1 and spi_cs_n to 1.
- mem_wr_en is never asserted outside RST_WR and TX_WR.
- Latency from a CMD/DATA fetch to the TX write asserting: 2 cycles (FETCH, DECODE).

Test Plan:
- ROM [0x0095, 0x403A, 0xC000], ready=1 after SETTLE:
  - CTRL write 0x02 held 4 cycles.
  - TX write 0x95 with oled_dc=0, then TX write 0x3A with oled_dc=1.
  - spi_cs_n low between the two transfers.
  - done pulse, err=0, busy=0.
- ROM [0x8003, 0xC000], DELAY_UNIT=10:
  - ≥30 cycles between leaving DECODE and FINISH.
  - No mem_wr_en asserted after the reset write.
- Ready held 0, POLL_TIMEOUT=50, ROM [0x00AE, 0xC000]:
  - err=1 and done pulse about 50 cycles after TX_SETTLE ends.
  - spi_cs_n=1 afterwards.
- ADDR_W=2, ROM of 4 CMD entries with no END:
  - 4 TX writes occur, then err=1 and done; seq_addr does not return to 0.
- rst asserted in DELAY, then start again:
  - Outputs return to reset values immediately.
  - The restarted run repeats the CTRL reset write and completes normally.
- start pulsed while busy:
  - No effect; seq_addr is unchanged and exactly one done pulse occurs.
